// File: rtl/axis_frame_gen_pkg.sv
// Shared definitions for the AXI-Stream frame generator and the matching frame checker.
package axis_frame_gen_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_SEND = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_GAP  = 2'd2;

  localparam int unsigned MAX_KEEP_WIDTH = 128;

  typedef logic [MAX_KEEP_WIDTH-1:0] keep_vec_t;

  // Last-beat byte-lane mask: len_mod low lanes set, or every lane when len_mod is 0 or a full beat.
  function automatic keep_vec_t keep_mask(input int unsigned len_mod, input int unsigned keep_width);
    keep_vec_t   mask;
    int unsigned lanes;
    lanes = ((len_mod == 0) || (len_mod >= keep_width)) ? keep_width : len_mod;
    mask  = '0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      mask[i] = (i < lanes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream test frame source: programmable length, count and gap with a
// seed-plus-offset byte pattern, fixed tid/tdest and optional bad-frame tuser.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned DEST_WIDTH  = 8,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned GAP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [7:0]            cfg_seed,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  input  logic                  cfg_bad,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  localparam logic [LEN_WIDTH-1:0] KW_LEN  = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [7:0]           KW_BYTE = 8'(KEEP_WIDTH);

  logic [STATE_WIDTH-1:0] state_q;
  logic [STATE_WIDTH-1:0] state_d;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic                  bad_q;
  logic                  stop_q;
  logic [7:0]            frame_base_q;
  logic [7:0]            cur_byte_q;
  logic [LEN_WIDTH-1:0]  cur_left_q;
  logic [GAP_WIDTH-1:0]  gap_cnt_q;

  logic                  hs;
  logic                  last_hs;
  logic                  run_end;
  logic [CNT_WIDTH-1:0]  sent_inc;
  logic [LEN_WIDTH-1:0]  start_len;

  logic                  load;
  logic [7:0]            ld_byte;
  logic [LEN_WIDTH-1:0]  ld_left;
  logic                  ld_bad;

  logic [DATA_WIDTH-1:0] fmt_data;
  logic [KEEP_WIDTH-1:0] fmt_keep;
  logic                  fmt_last;

  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_hs   = hs && m_axis_tlast;
  assign sent_inc  = frames_sent + CNT_WIDTH'(1);
  assign run_end   = stop_q || stop || ((count_q != '0) && (sent_inc == count_q));
  assign start_len = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and selection of the beat to load into the output register
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ld_byte = cur_byte_q;
    ld_left = cur_left_q;
    ld_bad  = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          load    = 1'b1;
          ld_byte = cfg_seed;
          ld_left = start_len;
          ld_bad  = cfg_bad;
        end
      end
      ST_SEND: begin
        if (hs && !m_axis_tlast) begin
          load    = 1'b1;
          ld_byte = cur_byte_q + KW_BYTE;
          ld_left = cur_left_q - KW_LEN;
        end else if (last_hs) begin
          if (run_end) begin
            state_d = ST_IDLE;
          end else if (gap_q == '0) begin
            load    = 1'b1;
            ld_byte = frame_base_q + 8'd1;
            ld_left = len_q;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = ST_SEND;
          load    = 1'b1;
          ld_byte = frame_base_q;
          ld_left = len_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat formatter: lane k carries ld_byte + k while bytes remain, zero otherwise
  always_comb begin
    fmt_data = '0;
    fmt_last = (ld_left <= KW_LEN);
    for (int unsigned k = 0; k < KEEP_WIDTH; k++) begin
      if (k < 32'(ld_left)) begin
        fmt_data[8*k +: 8] = ld_byte + 8'(k);
      end
    end
    fmt_keep = '1;
    if (KEEP_ENABLE && fmt_last) begin
      fmt_keep = KEEP_WIDTH'(keep_mask(32'(ld_left), KEEP_WIDTH));
    end
  end

  // Output register, run configuration and frame bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frames_sent   <= '0;
      len_q         <= '0;
      count_q       <= '0;
      gap_q         <= '0;
      bad_q         <= 1'b0;
      stop_q        <= 1'b0;
      frame_base_q  <= '0;
      cur_byte_q    <= '0;
      cur_left_q    <= '0;
      gap_cnt_q     <= '0;
    end else begin
      frame_done <= 1'b0;
      busy       <= (state_d != ST_IDLE);

      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= fmt_data;
        m_axis_tkeep  <= fmt_keep;
        m_axis_tlast  <= fmt_last;
        m_axis_tuser  <= {USER_WIDTH{fmt_last && ld_bad}};
        cur_byte_q    <= ld_byte;
        cur_left_q    <= ld_left;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end

      if ((state_q == ST_IDLE) && start) begin
        len_q        <= start_len;
        count_q      <= cfg_count;
        gap_q        <= cfg_gap;
        bad_q        <= cfg_bad;
        frame_base_q <= cfg_seed;
        m_axis_tid   <= cfg_id;
        m_axis_tdest <= cfg_dest;
        frames_sent  <= '0;
        stop_q       <= stop;
      end

      // stop is held until the frame in flight has fully left
      if (state_q == ST_SEND) begin
        if (stop) begin
          stop_q <= 1'b1;
        end
        if (last_hs) begin
          frame_done   <= 1'b1;
          frames_sent  <= sent_inc;
          stop_q       <= 1'b0;
          frame_base_q <= frame_base_q + 8'd1;
          gap_cnt_q    <= gap_q;
        end
      end

      if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
      end
    end
  end

endmodule
